range_poller: RTL and testbench
===============================

# range_poller

Periodic I2C sensor poller that sits directly upstream of the I2C master. Every poll period it runs a register-pointer write followed by a 2-byte read on the master's transaction interface. It then assembles a 16-bit big-endian distance sample and publishes it to the PID controller with a one-cycle valid strobe. Failed transactions (NACK or timeout) are retried a bounded number of times, then flagged as a fault.

## Interface
- `SLAVE_ADDR`, default 7'h29: 7-bit sensor address.
- `RESULT_REG`, default 8'h1E: register pointer written before each read.
- `POLL_CYCLES`, default 1_250_000: cycles between poll starts (10 ms at 125 MHz).
- `TIMEOUT_CYCLES`, default 200_000: maximum wait for `transaction_done`.
- `MAX_RETRIES`, default 3: retries per poll before fault.
- `clk`, in, 1: sole clock.
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: polling permitted.
- `i2c_start`, out, 1: one-cycle transaction request to the master.
- `i2c_rd_nwr`, out, 1: 0 = write, 1 = read.
- `i2c_slave_addr`, out, 7: always `SLAVE_ADDR`.
- `i2c_din`, out, 8×3 (`[0:2]`): `{RESULT_REG, 0, 0}`.
- `i2c_bytes_num`, out, 2: 1 for pointer write, 2 for read.
- `i2c_dout`, in, 8×3: read data from the master.
- `i2c_done`, in, 1: one-cycle completion pulse from the master.
- `i2c_error`, in, 1: master error flag; valid in the `i2c_done` cycle.
- `distance`, out, 16: last good sample.
- `distance_valid`, out, 1: one-cycle strobe when `distance` updates.
- `sensor_fault`, out, 1: high after retries are exhausted; cleared by the next good sample.
- `retry_count`, out, 2: retries used in the current poll.

## Operation
- **Reset values:** all outputs 0, except `i2c_slave_addr` = `SLAVE_ADDR` and `i2c_din` = `{RESULT_REG, 0, 0}`. State = IDLE, period counter = 0.
- **IDLE:** period counter runs only while `enable` = 1. When it reaches `POLL_CYCLES-1`, the counter wraps to 0 and the FSM goes to WR_REQ. If `enable` drops, the counter clears.
- **WR_REQ:** drive `i2c_rd_nwr` = 0 and `i2c_bytes_num` = 1, pulse `i2c_start`, then go to WR_WAIT.
- **WR_WAIT:** wait for `i2c_done`.
  - `i2c_done` with `i2c_error` = 0 → GAP, then RD_REQ.
  - `i2c_done` with `i2c_error` = 1, or timeout → FAIL.
- **RD_REQ:** drive `i2c_rd_nwr` = 1 and `i2c_bytes_num` = 2, pulse `i2c_start`, then go to RD_WAIT.
- **RD_WAIT:** wait for `i2c_done`.
  - Success → latch `distance` = `{i2c_dout[0], i2c_dout[1]}`, pulse `distance_valid`, clear `sensor_fault` and `retry_count`, go to IDLE.
  - Error or timeout → FAIL.
- **FAIL:**
  - If `retry_count` < `MAX_RETRIES`: increment `retry_count`, go to GAP, then WR_REQ. A retry always restarts from the pointer write.
  - Otherwise: set `sensor_fault`, clear `retry_count`, go to IDLE. `distance` keeps its old value.
- **GAP:** exactly one idle cycle. It guarantees the master has re-entered its ready state before the next `i2c_start`.
- **Timeout counter:** cleared on each `i2c_start`; counts in the WAIT states. A timeout fires at `TIMEOUT_CYCLES-1` without `i2c_done`. If `i2c_done` and the timeout terminal count coincide, `i2c_done` wins.
- **Ignored `i2c_done`:** a pulse outside the WAIT states has no effect.
- **`enable` deasserted mid-transaction:** the current transaction and its result or retries complete. The FSM then stays in IDLE.
- **Reset mid-transaction:** immediate return to IDLE. The master is reset by the same signal.

## Timing
- `i2c_start` is high for exactly one cycle, registered.
- Minimum spacing from `i2c_done` to the next `i2c_start` is 2 cycles (GAP + REQ).
- `distance_valid` is asserted the cycle after the read `i2c_done`. `distance` is stable from that cycle on.
- `sensor_fault` rises the cycle after the final FAIL.
- At most one transaction is outstanding at any time.

## Structure
- A shared package `range_pkg` holds:
  - the state enum `poll_state_t` (IDLE, WR_REQ, WR_WAIT, GAP, RD_REQ, RD_WAIT, FAIL);
  - the default constants `SENSOR_ADDR` and `RESULT_REG`.
- Optional sub-module `cycle_timer`: a loadable down-counter with terminal-count output. It is used twice, once for the poll period and once for the timeout.

## Test plan
Bench: behavioural master model, `POLL_CYCLES` = 100, `TIMEOUT_CYCLES` = 50.
- **Normal poll.** `enable` = 1; model returns `dout` = `{8'h01, 8'h2C}`. Required: first `i2c_start` at cycle 100 with `rd_nwr` = 0 and `bytes` = 1, then a read with `bytes` = 2, then `distance` = 16'h012C with a single `distance_valid` pulse.
- **Single NACK.** First write returns `error` = 1. Required: one retry with `retry_count` = 1, a good sample, `retry_count` back to 0, `sensor_fault` = 0.
- **Persistent error.** All transactions return error. Required: exactly 4 write attempts, `sensor_fault` = 1, `distance` unchanged, and the next poll still starts on schedule.
- **Timeout.** Model never pulses `i2c_done`. Required: FAIL 50 cycles after `i2c_start`; retries are counted as for errors.
- **Coincident done and timeout.** `i2c_done` arrives at timeout cycle 49. Required: treated as success.
- **Reset and enable edges.** Reset asserted during RD_WAIT → all outputs at reset values the next cycle. `enable` = 0 → no `i2c_start` over 500 cycles.

Source files
------------

// File: rtl/range_pkg.sv
// Shared definitions for the range poller: FSM state encoding, default
// sensor constants and small helpers used by the top level.
package range_pkg;

  // Poll sequencer states. The encoding is exported on the debug port.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_WAIT = 3'd2,
    GAP     = 3'd3,
    RD_REQ  = 3'd4,
    RD_WAIT = 3'd5,
    FAIL    = 3'd6
  } poll_state_t;

  // Default 7-bit I2C address of the ranging sensor.
  localparam logic [6:0] SENSOR_ADDR = 7'h29;

  // Default register pointer of the distance result.
  localparam logic [7:0] RESULT_REG = 8'h1E;

  // Byte counts requested from the I2C master.
  localparam logic [1:0] PTR_WRITE_BYTES = 2'd1;
  localparam logic [1:0] SAMPLE_READ_BYTES = 2'd2;

  // The sensor returns the sample MSB first.
  function automatic logic [15:0] be_sample(input logic [7:0] first,
                                            input logic [7:0] second);
    return {first, second};
  endfunction

  // True for the states in which a master completion is expected.
  function automatic logic is_wait_state(input poll_state_t s);
    return (s == WR_WAIT) || (s == RD_WAIT);
  endfunction

  // True for the states in which the timeout budget is being consumed.
  function automatic logic is_busy_state(input poll_state_t s);
    return (s == WR_REQ) || (s == WR_WAIT) || (s == RD_REQ) || (s == RD_WAIT);
  endfunction

endpackage

// File: rtl/range_poller_cycle_timer.sv
// Loadable down-counter with a terminal-count flag. The count starts at
// CYCLES-1 and tc is high while the count sits at zero, so a timer that is
// loaded and then enabled every cycle flags tc on its CYCLES-th cycle.
module cycle_timer #(
  parameter int unsigned CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] RELOAD = W'(CYCLES - 1);

  logic [W-1:0] count;

  // Reload has priority; the count saturates at zero until reloaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= RELOAD;
    end else if (load) begin
      count <= RELOAD;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Terminal count is a pure decode of the current count.
  always_comb begin
    tc = (count == '0);
  end

endmodule

// File: rtl/range_poller.sv
// Periodic I2C distance-sensor poller. Each poll period it writes the
// result-register pointer, then reads two bytes, and publishes the
// big-endian sample with a one-cycle strobe. Failed transactions are retried
// from the pointer write a bounded number of times before a fault is raised.
//
// Master handshake: i2c_start is a registered one-cycle request carrying
// i2c_rd_nwr / i2c_bytes_num / i2c_slave_addr / i2c_din, which stay stable
// until the next request. The master answers with a one-cycle i2c_done; its
// i2c_error and i2c_dout are only meaningful in that cycle. Only one request
// is ever outstanding, and a done outside the wait states is ignored.
module range_poller
  import range_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR     = SENSOR_ADDR,
  parameter logic [7:0]  RESULT_REG     = range_pkg::RESULT_REG,
  parameter int unsigned POLL_CYCLES    = 1_250_000,
  parameter int unsigned TIMEOUT_CYCLES = 200_000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        i2c_start,
  output logic        i2c_rd_nwr,
  output logic [6:0]  i2c_slave_addr,
  output logic [7:0]  i2c_din [0:2],
  output logic [1:0]  i2c_bytes_num,
  input  logic [7:0]  i2c_dout [0:2],
  input  logic        i2c_done,
  input  logic        i2c_error,
  output logic [15:0] distance,
  output logic        distance_valid,
  output logic        sensor_fault,
  output logic [1:0]  retry_count,
  output poll_state_t state
);

  // retry_count is two bits wide, so the retry limit is held at that width.
  localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRIES);

  logic period_load;
  logic period_en;
  logic period_tc;
  logic timeout_load;
  logic timeout_en;
  logic timeout_tc;
  logic poll_go;
  logic gap_to_read;
  logic unused_dout;

  // Only the first two read bytes carry the sample.
  assign unused_dout = ^i2c_dout[2];

  // Transaction parameters that never change.
  always_comb begin
    i2c_slave_addr = SLAVE_ADDR;
    i2c_din[0]     = RESULT_REG;
    i2c_din[1]     = 8'h00;
    i2c_din[2]     = 8'h00;
  end

  // Timer control: the period timer free-runs while enabled and wraps on
  // terminal count; the timeout timer restarts with every request and runs
  // from the request cycle through the wait.
  always_comb begin
    poll_go      = (state == IDLE) && enable && period_tc;
    period_en    = enable;
    period_load  = !enable || period_tc;
    timeout_load = poll_go || (state == GAP);
    timeout_en   = is_busy_state(state);
  end

  cycle_timer #(
    .CYCLES (POLL_CYCLES)
  ) u_period_timer (
    .clk   (clk),
    .reset (reset),
    .load  (period_load),
    .en    (period_en),
    .tc    (period_tc)
  );

  cycle_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timeout_load),
    .en    (timeout_en),
    .tc    (timeout_tc)
  );

  // Poll sequencer with registered master requests and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      i2c_start      <= 1'b0;
      i2c_rd_nwr     <= 1'b0;
      i2c_bytes_num  <= 2'd0;
      distance       <= 16'h0000;
      distance_valid <= 1'b0;
      sensor_fault   <= 1'b0;
      retry_count    <= 2'd0;
      gap_to_read    <= 1'b0;
    end else begin
      i2c_start      <= 1'b0;
      distance_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (poll_go) begin
            state         <= WR_REQ;
            i2c_start     <= 1'b1;
            i2c_rd_nwr    <= 1'b0;
            i2c_bytes_num <= PTR_WRITE_BYTES;
          end
        end
        WR_REQ: begin
          state <= WR_WAIT;
        end
        WR_WAIT: begin
          // A completion in the terminal-count cycle still counts.
          if (i2c_done) begin
            if (i2c_error) begin
              state <= FAIL;
            end else begin
              state       <= GAP;
              gap_to_read <= 1'b1;
            end
          end else if (timeout_tc) begin
            state <= FAIL;
          end
        end
        GAP: begin
          if (gap_to_read) begin
            state         <= RD_REQ;
            i2c_rd_nwr    <= 1'b1;
            i2c_bytes_num <= SAMPLE_READ_BYTES;
          end else begin
            state         <= WR_REQ;
            i2c_rd_nwr    <= 1'b0;
            i2c_bytes_num <= PTR_WRITE_BYTES;
          end
          i2c_start <= 1'b1;
        end
        RD_REQ: begin
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (i2c_done) begin
            if (i2c_error) begin
              state <= FAIL;
            end else begin
              state          <= IDLE;
              distance       <= be_sample(i2c_dout[0], i2c_dout[1]);
              distance_valid <= 1'b1;
              sensor_fault   <= 1'b0;
              retry_count    <= 2'd0;
            end
          end else if (timeout_tc) begin
            state <= FAIL;
          end
        end
        FAIL: begin
          // A retry always restarts from the pointer write.
          if (retry_count < RETRY_LIMIT) begin
            state       <= GAP;
            retry_count <= retry_count + 2'd1;
            gap_to_read <= 1'b0;
          end else begin
            state        <= IDLE;
            sensor_fault <= 1'b1;
            retry_count  <= 2'd0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_range_poller.sv
// Directed bench for range_poller with a task-based master model.
// POLL_CYCLES = 100, TIMEOUT_CYCLES = 50.
module tb_range_poller;
  import range_pkg::*;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        i2c_start;
  logic        i2c_rd_nwr;
  logic [6:0]  i2c_slave_addr;
  logic [7:0]  i2c_din [0:2];
  logic [1:0]  i2c_bytes_num;
  logic [7:0]  i2c_dout [0:2];
  logic        i2c_done;
  logic        i2c_error;
  logic [15:0] distance;
  logic        distance_valid;
  logic        sensor_fault;
  logic [1:0]  retry_count;
  poll_state_t state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cnt = 0;
  int wr_cnt = 0;
  int dv_cnt = 0;

  range_poller #(
    .SLAVE_ADDR     (7'h29),
    .RESULT_REG     (8'h1E),
    .POLL_CYCLES    (100),
    .TIMEOUT_CYCLES (50),
    .MAX_RETRIES    (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .i2c_start      (i2c_start),
    .i2c_rd_nwr     (i2c_rd_nwr),
    .i2c_slave_addr (i2c_slave_addr),
    .i2c_din        (i2c_din),
    .i2c_bytes_num  (i2c_bytes_num),
    .i2c_dout       (i2c_dout),
    .i2c_done       (i2c_done),
    .i2c_error      (i2c_error),
    .distance       (distance),
    .distance_valid (distance_valid),
    .sensor_fault   (sensor_fault),
    .retry_count    (retry_count),
    .state          (state)
  );

  // Clock and cycle numbering: cyc = number of posedges since reset release.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc = 0;
    else cyc = cyc + 1;
  end

  // Event counters sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (i2c_start) start_cnt = start_cnt + 1;
      if (i2c_start && !i2c_rd_nwr) wr_cnt = wr_cnt + 1;
      if (distance_valid) dv_cnt = dv_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a request; returns the number of cycles waited.
  task automatic wait_start(input string tag, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!i2c_start && waited < 1000);
    check({tag, " start seen"}, 32'(i2c_start), 32'd1);
  endtask

  // Master model: completion 'delay' cycles after the request cycle.
  task automatic respond(input int delay, input logic err,
                         input logic [7:0] d0, input logic [7:0] d1);
    repeat (delay) @(negedge clk);
    i2c_done    = 1'b1;
    i2c_error   = err;
    i2c_dout[0] = d0;
    i2c_dout[1] = d1;
    @(negedge clk);
    i2c_done  = 1'b0;
    i2c_error = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " state"}, 32'(state), 32'(IDLE));
    check({tag, " start"}, 32'(i2c_start), 32'd0);
    check({tag, " rd_nwr"}, 32'(i2c_rd_nwr), 32'd0);
    check({tag, " bytes"}, 32'(i2c_bytes_num), 32'd0);
    check({tag, " distance"}, 32'(distance), 32'd0);
    check({tag, " dv"}, 32'(distance_valid), 32'd0);
    check({tag, " fault"}, 32'(sensor_fault), 32'd0);
    check({tag, " retry"}, 32'(retry_count), 32'd0);
    check({tag, " addr"}, 32'(i2c_slave_addr), 32'h29);
    check({tag, " din0"}, 32'(i2c_din[0]), 32'h1E);
    check({tag, " din1"}, 32'(i2c_din[1]), 32'h00);
    check({tag, " din2"}, 32'(i2c_din[2]), 32'h00);
  endtask

  // Hard stop so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int snap;
    reset = 1'b1;
    enable = 1'b0;
    i2c_done = 1'b0;
    i2c_error = 1'b0;
    for (int i = 0; i < 3; i++) i2c_dout[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("rst");

    // Normal poll: write at cycle 100, read 2 cycles after done.
    reset = 1'b0;
    enable = 1'b1;
    wait_start("p1 wr", n);
    check("p1 wr cycle", 32'(cyc), 32'd100);
    check("p1 wr rd_nwr", 32'(i2c_rd_nwr), 32'd0);
    check("p1 wr bytes", 32'(i2c_bytes_num), 32'd1);
    respond(2, 1'b0, 8'h00, 8'h00);
    wait_start("p1 rd", n);
    check("p1 rd cycle", 32'(cyc), 32'd104);
    check("p1 rd rd_nwr", 32'(i2c_rd_nwr), 32'd1);
    check("p1 rd bytes", 32'(i2c_bytes_num), 32'd2);
    respond(3, 1'b0, 8'h01, 8'h2C);
    check("p1 dv", 32'(distance_valid), 32'd1);
    check("p1 distance", 32'(distance), 32'h012C);
    check("p1 fault", 32'(sensor_fault), 32'd0);
    @(negedge clk);
    check("p1 dv drop", 32'(distance_valid), 32'd0);
    check("p1 distance hold", 32'(distance), 32'h012C);
    @(negedge clk);
    check("p1 dv pulses", 32'(dv_cnt), 32'd1);

    // Single NACK on the first write.
    wait_start("p2 wr0", n);
    check("p2 wr0 cycle", 32'(cyc), 32'd200);
    respond(1, 1'b1, 8'h00, 8'h00);
    check("p2 fail state", 32'(state), 32'(FAIL));
    check("p2 retry before", 32'(retry_count), 32'd0);
    wait_start("p2 wr1", n);
    check("p2 wr1 cycle", 32'(cyc), 32'd204);
    check("p2 wr1 rd_nwr", 32'(i2c_rd_nwr), 32'd0);
    check("p2 retry", 32'(retry_count), 32'd1);
    respond(1, 1'b0, 8'h00, 8'h00);
    wait_start("p2 rd", n);
    check("p2 rd cycle", 32'(cyc), 32'd207);
    respond(1, 1'b0, 8'h12, 8'h34);
    check("p2 dv", 32'(distance_valid), 32'd1);
    check("p2 distance", 32'(distance), 32'h1234);
    check("p2 retry clear", 32'(retry_count), 32'd0);
    check("p2 fault", 32'(sensor_fault), 32'd0);

    // Persistent error: four writes, then fault.
    snap = wr_cnt;
    for (int a = 0; a < 4; a++) begin
      wait_start("p3 wr", n);
      check("p3 wr cycle", 32'(cyc), 32'(300 + 4 * a));
      check("p3 wr rd_nwr", 32'(i2c_rd_nwr), 32'd0);
      check("p3 retry", 32'(retry_count), 32'(a));
      respond(1, 1'b1, 8'hFF, 8'hFF);
    end
    check("p3 last fail", 32'(state), 32'(FAIL));
    check("p3 retry max", 32'(retry_count), 32'd3);
    check("p3 no fault yet", 32'(sensor_fault), 32'd0);
    @(negedge clk);
    check("p3 fault", 32'(sensor_fault), 32'd1);
    check("p3 retry reset", 32'(retry_count), 32'd0);
    check("p3 idle", 32'(state), 32'(IDLE));
    check("p3 distance kept", 32'(distance), 32'h1234);
    check("p3 write count", 32'(wr_cnt - snap), 32'd4);

    // Timeout on the write, then done coincident with read timeout.
    wait_start("p4 wr0", n);
    check("p4 on schedule", 32'(cyc), 32'd400);
    repeat (49) @(negedge clk);
    check("p4 still waiting", 32'(state), 32'(WR_WAIT));
    @(negedge clk);
    check("p4 timeout fail", 32'(state), 32'(FAIL));
    wait_start("p4 wr1", n);
    check("p4 wr1 cycle", 32'(cyc), 32'd452);
    check("p4 retry", 32'(retry_count), 32'd1);
    respond(1, 1'b0, 8'h00, 8'h00);
    wait_start("p4 rd", n);
    check("p4 rd cycle", 32'(cyc), 32'd455);
    respond(49, 1'b0, 8'hAB, 8'hCD);
    check("p4 coincident dv", 32'(distance_valid), 32'd1);
    check("p4 distance", 32'(distance), 32'hABCD);
    check("p4 fault cleared", 32'(sensor_fault), 32'd0);
    check("p4 retry clear", 32'(retry_count), 32'd0);

    // Reset during RD_WAIT.
    wait_start("p5 wr", n);
    check("p5 wr cycle", 32'(cyc), 32'd600);
    respond(1, 1'b0, 8'h00, 8'h00);
    wait_start("p5 rd", n);
    @(negedge clk);
    check("p5 in rd_wait", 32'(state), 32'(RD_WAIT));
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("p5 rst");

    // Enable low: stray done ignored, no requests for 500 cycles.
    reset = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    i2c_done = 1'b1;
    @(negedge clk);
    i2c_done = 1'b0;
    @(negedge clk);
    check("stray done state", 32'(state), 32'(IDLE));
    check("stray done dv", 32'(distance_valid), 32'd0);
    snap = start_cnt;
    repeat (500) @(negedge clk);
    check("disabled starts", 32'(start_cnt - snap), 32'd0);
    enable = 1'b1;
    wait_start("re-enable", n);
    check("re-enable delay", 32'(n), 32'd100);
    check("re-enable bytes", 32'(i2c_bytes_num), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
